// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Stall/flush/hold generator for the five-stage pipeline. Detects load-use
//   hazards, taken-branch redirects and data-memory wait states. A small FSM
//   tracks memory wait cycles and raises a one-cycle fault pulse on timeout.
//
//   Optional build macro: HAZARD_PERF_COUNTERS_EN
//     defined   -> saturating perf counters for stalls, flushes and waits
//     undefined -> perf ports are tied to zero, no counter flops
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_RUN    | normal flow, no outstanding memory wait
//   ST_MEM_WAIT | data memory stalled, whole pipe held, timeout counting
//   ST_FAULT  | one cycle after timeout: fault pulse, flush IF/ID and ID/EX

module hazard_control_unit #(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_id_valid,
    input  logic [4:0]           i_id_rs1_addr,
    input  logic [4:0]           i_id_rs2_addr,
    input  logic                 i_id_uses_rs1,
    input  logic                 i_id_uses_rs2,
    input  logic                 i_ex_valid,
    input  logic                 i_ex_mem_read,
    input  logic [4:0]           i_ex_rd_addr,
    input  logic                 i_ex_branch_taken,
    input  logic                 i_mem_req,
    input  logic                 i_dmem_ready,
    output logic                 o_pc_stall,
    output logic                 o_if_id_stall,
    output logic                 o_if_id_flush,
    output logic                 o_id_ex_stall,
    output logic                 o_id_ex_flush,
    output logic                 o_hold_all,
    output logic                 o_mem_fault,
    output logic [CNT_WIDTH-1:0] o_perf_stall_cnt,
    output logic [CNT_WIDTH-1:0] o_perf_flush_cnt,
    output logic [CNT_WIDTH-1:0] o_perf_wait_cnt
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TW-1:0]   r_wait_cnt;
    logic [TW-1:0]   w_wait_cnt_nxt;
    logic            r_mem_fault;

    logic            w_load_use;
    logic            w_branch;
    logic            w_mem_wait;
    logic            w_lu_stall_eff;
    logic            w_br_flush_eff;

    // Hazard detection terms
    always_comb begin
        w_load_use = i_ex_valid & i_id_valid & i_ex_mem_read & (i_ex_rd_addr != 5'd0)
                   & ((i_id_uses_rs1 & (i_id_rs1_addr == i_ex_rd_addr))
                    | (i_id_uses_rs2 & (i_id_rs2_addr == i_ex_rd_addr)));
        w_branch   = i_ex_valid & i_ex_branch_taken;
        w_mem_wait = i_mem_req & ~i_dmem_ready & (r_state != ST_FAULT);
    end

    // Pipeline control outputs, priority mem_wait > fault/branch > load_use
    always_comb begin
        o_pc_stall     = 1'b0;
        o_if_id_stall  = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_stall  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_hold_all     = 1'b0;
        w_lu_stall_eff = 1'b0;
        w_br_flush_eff = 1'b0;
        if (w_mem_wait) begin
            o_hold_all    = 1'b1;
            o_pc_stall    = 1'b1;
            o_if_id_stall = 1'b1;
            o_id_ex_stall = 1'b1;
        end else if ((r_state == ST_FAULT) || w_branch) begin
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
            w_br_flush_eff = w_branch;
        end else if (w_load_use) begin
            o_pc_stall     = 1'b1;
            o_if_id_stall  = 1'b1;
            o_id_ex_flush  = 1'b1;
            w_lu_stall_eff = 1'b1;
        end
    end

    // Memory-wait FSM next state and timeout counter
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_mem_wait) begin
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_cnt_nxt = TW'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (!i_mem_req || i_dmem_ready) begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == TW'(MEM_TIMEOUT - 1)) begin
                    w_state_nxt    = ST_FAULT;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + TW'(1);
                end
            end
            ST_FAULT: begin
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // FSM state, counter and registered fault pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_mem_fault <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_mem_fault <= (w_state_nxt == ST_FAULT);
        end
    end

    assign o_mem_fault = r_mem_fault;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] r_perf_stall_cnt;
    logic [CNT_WIDTH-1:0] r_perf_flush_cnt;
    logic [CNT_WIDTH-1:0] r_perf_wait_cnt;

    // Saturating event counters; they stick at all-ones instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_stall_cnt <= '0;
            r_perf_flush_cnt <= '0;
            r_perf_wait_cnt  <= '0;
        end else begin
            if (w_lu_stall_eff && (r_perf_stall_cnt != '1))
                r_perf_stall_cnt <= r_perf_stall_cnt + CNT_WIDTH'(1);
            if (w_br_flush_eff && (r_perf_flush_cnt != '1))
                r_perf_flush_cnt <= r_perf_flush_cnt + CNT_WIDTH'(1);
            if (o_hold_all && (r_perf_wait_cnt != '1))
                r_perf_wait_cnt <= r_perf_wait_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_perf_stall_cnt = r_perf_stall_cnt;
    assign o_perf_flush_cnt = r_perf_flush_cnt;
    assign o_perf_wait_cnt  = r_perf_wait_cnt;
`else
    logic w_perf_unused;
    assign w_perf_unused    = w_lu_stall_eff ^ w_br_flush_eff;
    assign o_perf_stall_cnt = '0;
    assign o_perf_flush_cnt = '0;
    assign o_perf_wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit (MEM_TIMEOUT=4, CNT_WIDTH=2).
// Expected control vectors are queued when stimulus is applied and popped
// when the combinational outputs are sampled on the falling edge.

module tb_hazard_control_unit;

    localparam int MT = 4;
    localparam int CW = 2;

    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, hold_all, mem_fault}
    localparam logic [6:0] E_IDLE  = 7'b0000000;
    localparam logic [6:0] E_LU    = 7'b1100100;
    localparam logic [6:0] E_BR    = 7'b0010100;
    localparam logic [6:0] E_MW    = 7'b1101010;
    localparam logic [6:0] E_FAULT = 7'b0010101;

    typedef struct packed {
        logic       id_v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       ex_v;
        logic       ex_mr;
        logic [4:0] rd;
        logic       br;
        logic       mreq;
        logic       rdy;
        logic [6:0] exp;
    } stim_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          id_valid = 0, id_uses_rs1 = 0, id_uses_rs2 = 0;
    logic [4:0]    id_rs1_addr = '0, id_rs2_addr = '0, ex_rd_addr = '0;
    logic          ex_valid = 0, ex_mem_read = 0, ex_branch_taken = 0;
    logic          mem_req = 0, dmem_ready = 0;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, hold_all, mem_fault;
    logic [CW-1:0] perf_stall_cnt, perf_flush_cnt, perf_wait_cnt;

    logic [6:0]    exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;

    hazard_control_unit #(.MEM_TIMEOUT(MT), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_id_valid       (id_valid),
        .i_id_rs1_addr    (id_rs1_addr),
        .i_id_rs2_addr    (id_rs2_addr),
        .i_id_uses_rs1    (id_uses_rs1),
        .i_id_uses_rs2    (id_uses_rs2),
        .i_ex_valid       (ex_valid),
        .i_ex_mem_read    (ex_mem_read),
        .i_ex_rd_addr     (ex_rd_addr),
        .i_ex_branch_taken(ex_branch_taken),
        .i_mem_req        (mem_req),
        .i_dmem_ready     (dmem_ready),
        .o_pc_stall       (pc_stall),
        .o_if_id_stall    (if_id_stall),
        .o_if_id_flush    (if_id_flush),
        .o_id_ex_stall    (id_ex_stall),
        .o_id_ex_flush    (id_ex_flush),
        .o_hold_all       (hold_all),
        .o_mem_fault      (mem_fault),
        .o_perf_stall_cnt (perf_stall_cnt),
        .o_perf_flush_cnt (perf_flush_cnt),
        .o_perf_wait_cnt  (perf_wait_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, hold_all, mem_fault};
    endfunction

    function automatic stim_t mk(logic id_v, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                 logic ex_v, logic ex_mr, logic [4:0] rd, logic br,
                                 logic mreq, logic rdy, logic [6:0] exp);
        stim_t s;
        s = '{id_v, rs1, rs2, u1, u2, ex_v, ex_mr, rd, br, mreq, rdy, exp};
        return s;
    endfunction

    // One pipeline cycle: drive just after the rising edge, queue the expectation
    task automatic apply(input stim_t s);
        @(posedge clk);
        #1;
        id_valid = s.id_v;  id_rs1_addr = s.rs1; id_rs2_addr = s.rs2;
        id_uses_rs1 = s.u1; id_uses_rs2 = s.u2;
        ex_valid = s.ex_v;  ex_mem_read = s.ex_mr; ex_rd_addr = s.rd;
        ex_branch_taken = s.br; mem_req = s.mreq; dmem_ready = s.rdy;
        exp_q.push_back(s.exp);
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        reset = 1'b1;
        apply(mk(0,0,0,0,0, 0,0,0, 0,0,0, E_IDLE));
        @(negedge clk);
        exp = exp_q.pop_front();
        n_checks++;
        if (outs() !== exp) $display("FAIL reset_ctrl got=%b exp=%b", outs(), exp);
        else n_pass++;
        n_checks++;
        if ({perf_stall_cnt, perf_flush_cnt, perf_wait_cnt} !== '0)
            $display("FAIL reset_perf got=%h/%h/%h exp=0", perf_stall_cnt, perf_flush_cnt, perf_wait_cnt);
        else n_pass++;
        @(posedge clk); #2; reset = 1'b0;
    endtask

    task automatic test_load_use();
        stim_t v[$];
        logic [6:0] exp;
        v.push_back(mk(1,5,1,1,1, 1,1,5, 0,0,0, E_LU));    // lw x5 ; add x6,x5,x1
        v.push_back(mk(1,5,1,1,1, 0,0,0, 0,0,0, E_IDLE));  // bubble now in EX
        v.push_back(mk(1,0,2,1,1, 1,1,0, 0,0,0, E_IDLE));  // load to x0
        v.push_back(mk(1,3,5,1,0, 1,1,5, 0,0,0, E_IDLE));  // rs2 match but unused
        v.push_back(mk(1,3,5,1,1, 1,1,5, 0,0,0, E_LU));    // rs2 match used
        v.push_back(mk(1,5,5,1,1, 1,0,5, 0,0,0, E_IDLE));  // not a load
        v.push_back(mk(0,5,5,1,1, 1,1,5, 0,0,0, E_IDLE));  // ID invalid
        v.push_back(mk(1,5,5,1,1, 0,1,5, 0,0,0, E_IDLE));  // EX invalid
        v.push_back(mk(1,31,7,0,1, 1,1,7, 0,0,0, E_LU));
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            exp = exp_q.pop_front();
            n_checks++;
            if (outs() !== exp) $display("FAIL load_use[%0d] got=%b exp=%b", i, outs(), exp);
            else n_pass++;
        end
    endtask

    task automatic test_branch();
        stim_t v[$];
        logic [6:0] exp;
        v.push_back(mk(1,5,0,1,0, 1,1,5, 1,0,0, E_BR));    // branch beats load-use
        v.push_back(mk(0,0,0,0,0, 1,0,0, 1,0,0, E_BR));
        v.push_back(mk(0,0,0,0,0, 0,0,0, 1,0,0, E_IDLE));  // taken flag on invalid EX
        v.push_back(mk(1,5,0,1,0, 1,1,5, 1,1,0, E_MW));    // memory wait defers branch
        v.push_back(mk(1,5,0,1,0, 1,1,5, 1,1,0, E_MW));
        v.push_back(mk(1,5,0,1,0, 1,1,5, 1,1,1, E_BR));    // ready: hold drops, branch acts
        v.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0, E_IDLE));
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            exp = exp_q.pop_front();
            n_checks++;
            if (outs() !== exp) $display("FAIL branch[%0d] got=%b exp=%b", i, outs(), exp);
            else n_pass++;
        end
    endtask

    task automatic test_mem_wait();
        stim_t v[$];
        logic [6:0] exp;
        for (int k = 0; k < 3; k++) v.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,0, E_MW));
        v.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,1, E_IDLE));
        v.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,1, E_IDLE));  // immediate ready in RUN
        v.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0, E_IDLE));
        // mem_req drops mid-wait, then a fresh wait must run the full timeout
        v.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,0, E_MW));
        v.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,0, E_MW));
        v.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0, E_IDLE));
        for (int k = 0; k < 3; k++) v.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,0, E_MW));
        v.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,1, E_IDLE));
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            exp = exp_q.pop_front();
            n_checks++;
            if (outs() !== exp) $display("FAIL mem_wait[%0d] got=%b exp=%b", i, outs(), exp);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        stim_t v[$];
        logic [6:0] exp;
        for (int k = 0; k < MT; k++) v.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,0, E_MW));
        v.push_back(mk(1,5,0,1,0, 1,1,5, 0,1,0, E_FAULT)); // fault cycle masks wait and load-use
        v.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0, E_IDLE));
        v.push_back(mk(1,5,0,1,0, 1,1,5, 0,0,0, E_LU));    // back in RUN
        v.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0, E_IDLE));
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            exp = exp_q.pop_front();
            n_checks++;
            if (outs() !== exp) $display("FAIL timeout[%0d] got=%b exp=%b", i, outs(), exp);
            else n_pass++;
        end
    endtask

    task automatic test_perf();
        stim_t v[$];
        logic [6:0] exp;
        logic [3*CW-1:0] exp_cnt;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        for (int k = 0; k < 5; k++) v.push_back(mk(1,5'(k+1),0,1,0, 1,1,5'(k+1), 0,0,0, E_LU));
        v.push_back(mk(0,0,0,0,0, 1,0,0, 1,0,0, E_BR));
        v.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,0, E_MW));
        v.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,0, E_MW));
        v.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,1, E_IDLE));
        v.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0, E_IDLE));
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            exp = exp_q.pop_front();
            n_checks++;
            if (outs() !== exp) $display("FAIL perf_seq[%0d] got=%b exp=%b", i, outs(), exp);
            else n_pass++;
        end
`ifdef HAZARD_PERF_COUNTERS_EN
        exp_cnt = {2'd3, 2'd1, 2'd2};
`else
        exp_cnt = '0;
`endif
        n_checks++;
        if ({perf_stall_cnt, perf_flush_cnt, perf_wait_cnt} !== exp_cnt)
            $display("FAIL perf_counts got=%h exp=%h", {perf_stall_cnt, perf_flush_cnt, perf_wait_cnt}, exp_cnt);
        else n_pass++;

        // Reset in the middle of a memory wait
        apply(mk(0,0,0,0,0, 0,0,0, 0,1,0, E_MW));
        @(negedge clk); exp = exp_q.pop_front();
        n_checks++;
        if (outs() !== exp) $display("FAIL rst_wait0 got=%b exp=%b", outs(), exp);
        else n_pass++;
        apply(mk(0,0,0,0,0, 0,0,0, 0,1,0, E_MW));
        @(negedge clk); exp = exp_q.pop_front();
        n_checks++;
        if (outs() !== exp) $display("FAIL rst_wait1 got=%b exp=%b", outs(), exp);
        else n_pass++;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({perf_stall_cnt, perf_flush_cnt, perf_wait_cnt, mem_fault} !== '0)
            $display("FAIL rst_mid_wait got=%h/%h/%h fault=%b exp=0", perf_stall_cnt, perf_flush_cnt, perf_wait_cnt, mem_fault);
        else n_pass++;
        mem_req = 1'b0;
        @(posedge clk); #2; reset = 1'b0;
        for (int k = 0; k < MT + 2; k++) begin
            apply(mk(0,0,0,0,0, 0,0,0, 0,0,0, E_IDLE));
            @(negedge clk);
            exp = exp_q.pop_front();
            n_checks++;
            if (outs() !== exp) $display("FAIL post_rst[%0d] got=%b exp=%b", k, outs(), exp);
            else n_pass++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_perf();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
